// File: rtl/uart_tx_queue.sv
// Transmit byte queue feeding the UART transmitter via tx_send/tx_busy,
// with a bounded wait for the transmitter to acknowledge each send.
module uart_tx_queue #(
   parameter int DEPTH        = 16,
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [7:0]             wr_data,
   input  logic                   clr_overflow,
   input  logic                   tx_busy,
   output logic                   tx_send,
   output logic [7:0]             tx_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(BUSY_TIMEOUT - 1);
   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [TW-1:0] tmr;
   logic [TW-1:0] tmr_nx;
   logic          push;
   logic          pop;
   logic          load;

   assign full  = (level == LVL_FULL);
   assign empty = (level == '0);
   assign push  = wr_en && !full;

   always_comb begin
      state_nx = state;
      tmr_nx   = tmr;
      load     = 1'b0;
      pop      = 1'b0;
      tx_send  = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty && !tx_busy) begin
               load     = 1'b1;
               state_nx = SEND;
            end
         end
         SEND: begin
            tx_send  = 1'b1;
            pop      = 1'b1;
            tmr_nx   = '0;
            state_nx = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            // a transmitter that never raises busy must not stall the queue
            if (tx_busy) begin
               state_nx = WAIT_DONE;
            end else if (tmr == T_LAST) begin
               state_nx = IDLE;
            end else begin
               tmr_nx = tmr + 1'b1;
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         tmr      <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
         tx_data  <= 8'h00;
      end else begin
         state <= state_nx;
         tmr   <= tmr_nx;
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            level <= level + 1'b1;
         end else if (pop && !push) begin
            level <= level - 1'b1;
         end
         // a dropped write outranks a simultaneous clear
         if (wr_en && full) begin
            overflow <= 1'b1;
         end else if (clr_overflow) begin
            overflow <= 1'b0;
         end
         if (load) begin
            tx_data <= mem[rd_ptr];
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: vector table, directed corner sequences and
// random traffic against a queue-based scoreboard with a transmitter model.
module tb_uart_tx_queue;

   localparam int DEPTH = 16;
   localparam int BT    = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          wr_en = 1'b0;
   logic [7:0]    wr_data = 8'h00;
   logic          clr_overflow = 1'b0;
   logic          tx_busy = 1'b0;
   logic          tx_send;
   logic [7:0]    tx_data;
   logic          full;
   logic          empty;
   logic [LW-1:0] level;
   logic          overflow;

   always #5 clk = ~clk;

   uart_tx_queue #(
      .DEPTH(DEPTH),
      .BUSY_TIMEOUT(BT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .wr_en(wr_en),
      .wr_data(wr_data),
      .clr_overflow(clr_overflow),
      .tx_busy(tx_busy),
      .tx_send(tx_send),
      .tx_data(tx_data),
      .full(full),
      .empty(empty),
      .level(level),
      .overflow(overflow)
   );

   int errors = 0;
   int checks = 0;

   // reference: queue contents, sticky flag, a pop pending at the next edge
   logic [7:0] mq[$];
   bit         movf = 1'b0;
   bit         pend = 1'b0;
   logic [7:0] out_log[$];
   int         t_log[$];
   int         cyc = 0;

   // transmitter model: 0 = forced level, 1 = fixed busy length, 2 = random
   int mode = 0;
   bit bforce = 1'b0;
   int blen = 20;
   int bcnt = 0;

   typedef struct {
      logic       we;
      logic [7:0] wd;
      logic       clr;
      logic       send;
      logic [7:0] data;
      int         lvl;
      logic       ovf;
   } vec_t;

   vec_t tbl[16];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic step();
      bit         acc;
      bit         drop;
      bit         rst_e;
      bit         c;
      bit         b0;
      logic [7:0] d;
      logic [7:0] td0;
      rst_e = !rst;
      acc   = wr_en && (mq.size() < DEPTH);
      drop  = wr_en && !acc;
      c     = clr_overflow;
      d     = wr_data;
      b0    = tx_busy;
      td0   = tx_data;
      @(posedge clk);
      #1;
      cyc++;
      if (rst_e) begin
         mq.delete();
         movf = 1'b0;
         pend = 1'b0;
      end else begin
         if (pend) void'(mq.pop_front());
         pend = 1'b0;
         if (acc) mq.push_back(d);
         if (drop) movf = 1'b1;
         else if (c) movf = 1'b0;
      end
      chk("level", 32'(level), 32'(mq.size()));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("overflow", 32'(overflow), 32'(movf));
      if (b0 && !rst_e) chk("data_stable", 32'(tx_data), 32'(td0));
      if (tx_send === 1'b1) begin
         chk("send_while_busy", 32'(b0), 32'd0);
         if (mq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_send: got data %0h with empty queue",
                     tx_data);
         end else begin
            chk("send_order", 32'(tx_data), 32'(mq[0]));
         end
         pend = 1'b1;
         out_log.push_back(tx_data);
         t_log.push_back(cyc);
      end
      case (mode)
         0: tx_busy = bforce;
         1: begin
            if (tx_send === 1'b1) bcnt = blen;
            tx_busy = (bcnt > 0);
            if (bcnt > 0) bcnt--;
         end
         default: begin
            if (tx_send === 1'b1)
               bcnt = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 8);
            tx_busy = (bcnt > 0);
            if (bcnt > 0) bcnt--;
         end
      endcase
   endtask

   task automatic idle(input int n);
      wr_en = 1'b0;
      clr_overflow = 1'b0;
      repeat (n) step();
   endtask

   task automatic push(input logic [7:0] b);
      wr_en = 1'b1;
      wr_data = b;
      step();
      wr_en = 1'b0;
   endtask

   task automatic wait_log(input int target, input int bound,
                           input string name);
      int k;
      k = 0;
      while (out_log.size() < target && k < bound) begin
         step();
         k++;
      end
      chk(name, 32'(out_log.size()), 32'(target));
   endtask

   initial begin
      int s0;
      int i;
      int k;

      tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1, 1'b0};
      tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1, 1'b0};
      tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 0, 1'b0};
      tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 0, 1'b0};
      tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 0, 1'b0};
      tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 0, 1'b0};
      tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 0, 1'b0};
      tbl[7]  = '{1'b1, 8'h11, 1'b0, 1'b0, 8'hA5, 1, 1'b0};
      tbl[8]  = '{1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 2, 1'b0};
      tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h11, 1, 1'b0};
      tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h11, 1, 1'b0};
      tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h11, 1, 1'b0};
      tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h11, 1, 1'b0};
      tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h11, 1, 1'b0};
      tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1, 1'b0};
      tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h22, 0, 1'b0};

      rst = 1'b0;
      step();
      step();
      chk("rst_send", 32'(tx_send), 32'd0);
      chk("rst_data", 32'(tx_data), 32'h00);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      rst = 1'b1;

      // single byte and timeout pacing, cycle by cycle
      for (int r = 0; r < 16; r++) begin
         wr_en = tbl[r].we;
         wr_data = tbl[r].wd;
         clr_overflow = tbl[r].clr;
         step();
         chk($sformatf("vec%0d_send", r), 32'(tx_send), 32'(tbl[r].send));
         chk($sformatf("vec%0d_data", r), 32'(tx_data), 32'(tbl[r].data));
         chk($sformatf("vec%0d_level", r), 32'(level), 32'(tbl[r].lvl));
         chk($sformatf("vec%0d_ovf", r), 32'(overflow), 32'(tbl[r].ovf));
      end
      idle(10);

      // burst against a transmitter busy for 20 cycles per byte
      mode = 1;
      blen = 20;
      idle(5);
      s0 = out_log.size();
      for (int b = 1; b <= 5; b++) push(8'(b));
      wait_log(s0 + 5, 400, "burst_count");
      for (int j = 0; j < 5; j++) begin
         if (s0 + j < out_log.size()) begin
            chk("burst_byte", 32'(out_log[s0+j]), 32'(j + 1));
            if (j > 0)
               chk("burst_gap_gt_busy",
                   32'(t_log[s0+j] - t_log[s0+j-1] > blen), 32'd1);
         end
      end
      idle(30);

      // transmitter never acknowledges
      mode = 0;
      bforce = 1'b0;
      tx_busy = 1'b0;
      idle(10);
      s0 = out_log.size();
      push(8'h31);
      push(8'h32);
      push(8'h33);
      wait_log(s0 + 3, 100, "timeout_count");
      if (out_log.size() >= s0 + 3) begin
         chk("timeout_gap1", 32'(t_log[s0+1] - t_log[s0]), 32'(2 + BT));
         chk("timeout_gap2", 32'(t_log[s0+2] - t_log[s0+1]), 32'(2 + BT));
      end
      idle(10);

      // fill while busy, overflow, clear
      bforce = 1'b1;
      tx_busy = 1'b1;
      idle(2);
      s0 = out_log.size();
      for (int j = 0; j <= DEPTH; j++) push(8'(8'h40 + j));
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_level", 32'(level), 32'(DEPTH));
      chk("fill_ovf", 32'(overflow), 32'd1);
      wr_en = 1'b1;
      wr_data = 8'hEE;
      clr_overflow = 1'b1;
      step();
      chk("set_wins", 32'(overflow), 32'd1);
      wr_en = 1'b0;
      step();
      chk("clr_ovf", 32'(overflow), 32'd0);
      clr_overflow = 1'b0;
      bforce = 1'b0;
      tx_busy = 1'b0;
      k = 0;
      while (tx_send !== 1'b1 && k < 10) begin
         step();
         k++;
      end
      chk("fill_first_send", 32'(tx_send), 32'd1);
      push(8'hEF);
      chk("drop_on_pop_ovf", 32'(overflow), 32'd1);
      chk("drop_on_pop_lvl", 32'(level), 32'(DEPTH - 1));
      clr_overflow = 1'b1;
      step();
      clr_overflow = 1'b0;
      mode = 1;
      blen = 2;
      wait_log(s0 + DEPTH, 1000, "fill_drain_count");
      idle(20);
      chk("fill_no_extra", 32'(out_log.size()), 32'(s0 + DEPTH));
      for (int j = 0; j < DEPTH; j++)
         if (s0 + j < out_log.size())
            chk("fill_byte", 32'(out_log[s0+j]), 32'(8'h40 + j));

      // pointer wrap, paced so nothing is dropped
      mode = 0;
      bforce = 1'b0;
      idle(5);
      s0 = out_log.size();
      i = 0;
      k = 0;
      while ((i < 3 * DEPTH || out_log.size() < s0 + 3 * DEPTH) && k < 3000) begin
         if (i < 3 * DEPTH && mq.size() < DEPTH) begin
            wr_en = 1'b1;
            wr_data = i[7:0];
            i++;
         end else begin
            wr_en = 1'b0;
         end
         step();
         k++;
      end
      wr_en = 1'b0;
      chk("wrap_count", 32'(out_log.size() - s0), 32'(3 * DEPTH));
      for (int j = 0; j < 3 * DEPTH; j++)
         if (s0 + j < out_log.size())
            chk("wrap_byte", 32'(out_log[s0+j]), 32'(j));
      idle(10);

      // reset while the transmitter is busy with the first byte
      mode = 1;
      blen = 20;
      idle(5);
      s0 = out_log.size();
      for (int b = 0; b < 4; b++) push(8'(8'h81 + b));
      step();
      chk("mid_busy", 32'(tx_busy), 32'd1);
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk("mid_rst_level", 32'(level), 32'd0);
      chk("mid_rst_empty", 32'(empty), 32'd1);
      chk("mid_rst_send", 32'(tx_send), 32'd0);
      idle(60);
      chk("mid_rst_no_pulse", 32'(out_log.size()), 32'(s0 + 1));
      push(8'h77);
      step();
      chk("post_rst_send", 32'(tx_send), 32'd1);
      chk("post_rst_data", 32'(tx_data), 32'h77);
      idle(30);

      // random traffic with an erratic transmitter
      mode = 2;
      for (int n = 0; n < 1500; n++) begin
         wr_en = ($urandom_range(0, 4) < 2);
         wr_data = 8'($urandom);
         clr_overflow = ($urandom_range(0, 19) == 0);
         step();
      end
      wr_en = 1'b0;
      clr_overflow = 1'b0;
      k = 0;
      while ((mq.size() != 0 || pend) && k < 3000) begin
         step();
         k++;
      end
      chk("rand_drained", 32'(mq.size()), 32'd0);
      chk("rand_level_zero", 32'(level), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Transmit-side byte queue that sits directly upstream of the UART core's transmitter. It accepts bytes from the CPU store path into a FIFO and drains them one at a time into the transmitter through its `tx_send` / `tx_busy` handshake. It also presents the byte on the transmit data lane. Software can therefore issue bursts of writes without polling `tx_busy` per byte.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries. Must be a power of two and ≥ 2.
- `BUSY_TIMEOUT`, 4: cycles after a send pulse to wait for `tx_busy` to rise before the byte is considered consumed.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, **synchronous, active-low**.
- `wr_en`  in  1  push `wr_data` this cycle.
- `wr_data`  in  8  byte to enqueue.
- `clr_overflow`  in  1  clears the sticky `overflow` flag.
- `tx_busy`  in  1  transmitter busy, from the UART core.
- `tx_send`  out  1  one-cycle send pulse to the UART core.
- `tx_data`  out  8  byte for the transmitter; drives the low byte of the UART I/O register lane.
- `full`  out  1  `level == DEPTH`.
- `empty`  out  1  `level == 0`.
- `level`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky; a write was dropped.

## Operation
- **FIFO**
  - Circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
  - `level` is a separate registered counter.
- **Push**
  - When `wr_en` is high and `full` is low, `wr_data` is written at the write pointer and `level` increments.
  - When `wr_en` is high and `full` is high, the byte is dropped and `overflow` is set. This holds even if a pop occurs in the same cycle: fullness is judged on the registered `level`.
- **Pop**
  - Occurs only in the SEND state.
  - A push and a pop in the same cycle leave `level` unchanged.
- **Overflow flag**
  - `clr_overflow` clears `overflow`.
  - If a dropped write and `clr_overflow` coincide, the set wins.
- **Drain FSM**, states IDLE, SEND, WAIT_BUSY, WAIT_DONE:
  - IDLE: when `!empty && !tx_busy`, load `tx_data` from the FIFO head and go to SEND.
  - SEND: `tx_send` = 1 for exactly this cycle, the FIFO pops, go to WAIT_BUSY.
  - WAIT_BUSY:
    - If `tx_busy` = 1, go to WAIT_DONE.
    - Otherwise, once BUSY_TIMEOUT cycles have elapsed in this state, go to IDLE.
  - WAIT_DONE: when `tx_busy` = 0, go to IDLE.
- `tx_data` is held stable from the IDLE→SEND transition until the next load. It is never changed while the transmitter may be sampling it.
- A new send never starts while `tx_busy` is high.

## Timing
- **Reset values:** `tx_send`=0, `tx_data`=8'h00, `level`=0, `empty`=1, `full`=0, `overflow`=0, FSM in IDLE, both pointers 0.
- **Reset mid-operation:** flushes the FIFO and returns the FSM to IDLE. `tx_send` is low from the first cycle after the reset edge. A byte already handed to the transmitter is not recalled.
- **Latency, empty queue and idle transmitter:**
  - `wr_en` in cycle N gives `level`=1 in N+1.
  - IDLE sees non-empty in N+1.
  - `tx_send` is high in N+2 with `tx_data` = the written byte.
  - `level` returns to 0 in N+3.
- **Back-to-back bytes:** minimum spacing between `tx_send` pulses is SEND + WAIT_BUSY + WAIT_DONE exit + IDLE = 4 cycles plus the transmitter busy time.
- **Flag timing:** `full`, `empty` and `level` are registered and update the cycle after the push or pop.
- **Wrap-around:** after DEPTH pushes and pops, the pointers wrap to 0 with no gap or reordering. Output order is strictly first-in, first-out.

## Test plan
- **Single byte:** reset, then push 8'hA5 with `tx_busy` held 0 → `tx_send` pulses exactly once 2 cycles later, `tx_data`=8'hA5, and `level` returns to 0.
- **Burst:** push 8'h01..8'h05 back-to-back, with a transmitter model holding `tx_busy` high for 20 cycles per send → five pulses in order 01..05, `tx_data` stable during each busy window, and no pulse while busy.
- **Fill and overflow:**
  - With `tx_busy` held 1, push DEPTH+1 bytes → `full`=1, `level`=DEPTH, `overflow`=1, and the last byte is absent from the drained stream.
  - Then assert `clr_overflow` → `overflow`=0.
- **Timeout:** `tx_busy` tied 0 (transmitter never acknowledges), push 3 bytes → three pulses spaced 2+BUSY_TIMEOUT cycles apart, and the FSM does not hang.
- **Wrap:** push and drain 3×DEPTH incrementing bytes → the output sequence matches the input exactly across pointer wrap.
- **Reset mid-drain:** push 4 bytes, assert `rst`=0 for one cycle during WAIT_DONE → the next cycle shows `level`=0, `empty`=1, `tx_send`=0, and FSM in IDLE, with no further pulses.
